// File: rtl/tlb_op_unit_if.sv
// tlb_op_unit_if -- op request bus from the memory stage to tlb_op_unit.
//   op_valid / op_ready : request handshake (transfer on op_valid & op_ready)
//   op_type             : 0=TLBWI, 1=TLBWR, 2=TLBR, 3=TLBP
//   cp0_index           : CP0 Index.index
//   cp0_entryhi         : {vpn2[18:0], asid[7:0]}
//   cp0_entrylo0/1      : {pfn, c[2:0], d, v, g}
// Modports: master = pipeline side, slave = tlb_op_unit side.
interface tlb_op_unit_if #(
  parameter int IDX_W = 4
);
  logic             op_valid;
  logic             op_ready;
  logic [1:0]       op_type;
  logic [IDX_W-1:0] cp0_index;
  logic [26:0]      cp0_entryhi;
  logic [24:0]      cp0_entrylo0;
  logic [24:0]      cp0_entrylo1;

  modport master (
    output op_valid, op_type, cp0_index, cp0_entryhi, cp0_entrylo0, cp0_entrylo1,
    input  op_ready
  );

  modport slave (
    input  op_valid, op_type, cp0_index, cp0_entryhi, cp0_entrylo0, cp0_entrylo1,
    output op_ready
  );
endinterface

// File: rtl/tlb_op_unit.sv
// tlb_op_unit -- executes TLBWI / TLBWR / TLBR / TLBP and owns CP0 Random.
// Ports:
//   clk, resetn        : clock, synchronous active-low reset
//   op (slave)         : op request bus (see tlb_op_unit_if)
//   wired_we/_wdata    : CP0 Wired write
//   random             : CP0 Random value
//   tlbw_valid/addr/data : TLB table write port
//   tlbra / tlbrd      : TLB table read address / combinational read data
//   probe_hit/index    : probe LUT result for EntryHi
//   wb_*               : CP0 writeback (wb_sel 0 = EntryHi/Lo0/Lo1, 1 = Index)
//   done               : op complete pulse
//   machine_check      : duplicate-entry pulse
// Optional feature: define TLB_MACHINE_CHECK_EN to suppress a TLB write whose
// EntryHi already matches a different entry and pulse machine_check instead.
// Entry packing (MSB first): vpn2[18:0], asid[7:0], g, pfn0[19:0], c0, d0, v0,
// pfn1[19:0], c1, d1, v1. EntryLo is 25 bits wide, so it carries only the low
// 19 PFN bits; the PFN MSB in the entry is written as zero and dropped on read.
module tlb_op_unit #(
  parameter int TLB_ENTRIES = 16,
  parameter int IDX_W       = $clog2(TLB_ENTRIES),
  parameter int ENTRY_W     = 78
) (
  input  logic               clk,
  input  logic               resetn,
  tlb_op_unit_if.slave       op,
  input  logic               wired_we,
  input  logic [IDX_W-1:0]   wired_wdata,
  output logic [IDX_W-1:0]   random,
  output logic               tlbw_valid,
  output logic [IDX_W-1:0]   tlbw_addr,
  output logic [ENTRY_W-1:0] tlbw_data,
  output logic [IDX_W-1:0]   tlbra,
  input  logic [ENTRY_W-1:0] tlbrd,
  input  logic               probe_hit,
  input  logic [IDX_W-1:0]   probe_index,
  output logic               wb_valid,
  output logic               wb_sel,
  output logic [26:0]        wb_entryhi,
  output logic [24:0]        wb_entrylo0,
  output logic [24:0]        wb_entrylo1,
  output logic [IDX_W:0]     wb_index,
  output logic               done,
  output logic               machine_check
);

  localparam logic [1:0] OP_TLBWI = 2'd0;
  localparam logic [1:0] OP_TLBWR = 2'd1;
  localparam logic [1:0] OP_TLBR  = 2'd2;
  localparam logic [1:0] OP_TLBP  = 2'd3;
  localparam logic [IDX_W-1:0] RAND_TOP = IDX_W'(TLB_ENTRIES - 1);

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_PROBE, S_DONE} state_t;

  state_t state_reg, state_next;

  logic [1:0]         op_type_reg;
  logic [IDX_W-1:0]   random_reg, wired_reg;
  logic               tlbw_valid_reg;
  logic [IDX_W-1:0]   tlbw_addr_reg, tlbra_reg;
  logic [ENTRY_W-1:0] tlbw_data_reg;
  logic               wb_valid_reg, wb_sel_reg, done_reg;
  logic [26:0]        wb_entryhi_reg;
  logic [24:0]        wb_entrylo0_reg, wb_entrylo1_reg;
  logic [IDX_W:0]     wb_index_reg;

  logic               accept;
  logic               is_write;
  logic [ENTRY_W-1:0] wr_entry;
  logic [24:0]        rd_lo [2];
  logic               unused_pfn_msb;

  assign accept      = op.op_valid && (state_reg == S_IDLE);
  assign op.op_ready = (state_reg == S_IDLE);
  assign is_write    = (op_type_reg == OP_TLBWI) || (op_type_reg == OP_TLBWR);

  // The entry holds a single global bit: set only if both halves are global.
  assign wr_entry = {op.cp0_entryhi,
                     op.cp0_entrylo0[0] & op.cp0_entrylo1[0],
                     1'b0, op.cp0_entrylo0[24:1],
                     1'b0, op.cp0_entrylo1[24:1]};

  // Rebuild EntryLo0/1 from the read entry; the shared g bit goes to both.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_rd_lo
      assign rd_lo[gi] = {tlbrd[48 - 25*gi -: 24], tlbrd[50]};
    end
  endgenerate
  assign unused_pfn_msb = tlbrd[49] ^ tlbrd[24];

  always_ff @(posedge clk) begin
    if (!resetn) state_reg <= S_IDLE;
    else         state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE:  if (accept) state_next = S_EXEC;
      S_EXEC:  state_next = (op_type_reg == OP_TLBP) ? S_PROBE : S_DONE;
      S_PROBE: state_next = S_DONE;
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Random counts down through [wired, TOP]; at or below wired it wraps to TOP,
  // which also pins it at TOP when wired >= TOP.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      random_reg <= RAND_TOP;
      wired_reg  <= '0;
    end else if (wired_we) begin
      random_reg <= RAND_TOP;
      wired_reg  <= wired_wdata;
    end else if (random_reg <= wired_reg) begin
      random_reg <= RAND_TOP;
    end else begin
      random_reg <= random_reg - 1'b1;
    end
  end

`ifdef TLB_MACHINE_CHECK_EN
  logic mc_pend_reg, mc_reg;
  always_ff @(posedge clk) begin
    if (!resetn) begin
      mc_pend_reg <= 1'b0;
      mc_reg      <= 1'b0;
    end else begin
      mc_reg <= 1'b0;
      if (state_reg == S_EXEC)
        mc_pend_reg <= is_write && probe_hit && (probe_index != tlbw_addr_reg);
      if (state_reg == S_DONE) begin
        mc_reg      <= mc_pend_reg;
        mc_pend_reg <= 1'b0;
      end
    end
  end
  assign machine_check = mc_reg;
`else
  assign machine_check = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!resetn) begin
      op_type_reg     <= OP_TLBWI;
      tlbw_valid_reg  <= 1'b0;
      tlbw_addr_reg   <= '0;
      tlbw_data_reg   <= '0;
      tlbra_reg       <= '0;
      wb_valid_reg    <= 1'b0;
      wb_sel_reg      <= 1'b0;
      wb_entryhi_reg  <= '0;
      wb_entrylo0_reg <= '0;
      wb_entrylo1_reg <= '0;
      wb_index_reg    <= '0;
      done_reg        <= 1'b0;
    end else begin
      tlbw_valid_reg <= 1'b0;
      wb_valid_reg   <= 1'b0;
      done_reg       <= 1'b0;
      case (state_reg)
        S_IDLE: begin
          if (accept) begin
            op_type_reg <= op.op_type;
            // Write target is fixed here, so TLBWR uses Random as seen at acceptance.
            if (op.op_type == OP_TLBWI || op.op_type == OP_TLBWR) begin
              tlbw_addr_reg <= (op.op_type == OP_TLBWR) ? random_reg : op.cp0_index;
              tlbw_data_reg <= wr_entry;
            end
            if (op.op_type == OP_TLBR) tlbra_reg <= op.cp0_index;
          end
        end
        S_EXEC: begin
          if (is_write) begin
`ifdef TLB_MACHINE_CHECK_EN
            tlbw_valid_reg <= !(probe_hit && (probe_index != tlbw_addr_reg));
`else
            tlbw_valid_reg <= 1'b1;
`endif
          end else if (op_type_reg == OP_TLBR) begin
            wb_sel_reg      <= 1'b0;
            wb_entryhi_reg  <= tlbrd[77:51];
            wb_entrylo0_reg <= rd_lo[0];
            wb_entrylo1_reg <= rd_lo[1];
          end
        end
        S_PROBE: begin
          wb_sel_reg   <= 1'b1;
          wb_index_reg <= {~probe_hit, probe_hit ? probe_index : {IDX_W{1'b0}}};
        end
        S_DONE: begin
          done_reg     <= 1'b1;
          wb_valid_reg <= (op_type_reg == OP_TLBR) || (op_type_reg == OP_TLBP);
        end
        default: ;
      endcase
    end
  end

  assign random      = random_reg;
  assign tlbw_valid  = tlbw_valid_reg;
  assign tlbw_addr   = tlbw_addr_reg;
  assign tlbw_data   = tlbw_data_reg;
  assign tlbra       = tlbra_reg;
  assign wb_valid    = wb_valid_reg;
  assign wb_sel      = wb_sel_reg;
  assign wb_entryhi  = wb_entryhi_reg;
  assign wb_entrylo0 = wb_entrylo0_reg;
  assign wb_entrylo1 = wb_entrylo1_reg;
  assign wb_index    = wb_index_reg;
  assign done        = done_reg;

endmodule
